// File: rtl/cam_pkg.sv
// ---------------------------------------------------------------------------
// cam_pkg -- shared types and helpers for the RAM-based CAM.
//
// Contents:
//   cam_op_t      request opcode (SEARCH / INSERT / DELETE / CLEAR)
//   ctrl_state_t  state encoding of the per-slice BRAM controller
//   cam_word_t    widest bitmap word any slice may use
//   bitmap_update set or clear one entry bit of a bitmap word; shared by the
//                 slice controller and the multi-slice CAM top
// ---------------------------------------------------------------------------
package cam_pkg;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_CLEAR  = 2'd3
  } cam_op_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RESP,
    ST_MOD,
    ST_CLR
  } ctrl_state_t;

  // Slices narrower than this zero-extend their word before calling the
  // helper and truncate the result back.
  localparam int unsigned CAM_WORD_MAX = 256;
  typedef logic [CAM_WORD_MAX-1:0]         cam_word_t;
  typedef logic [$clog2(CAM_WORD_MAX)-1:0] cam_bit_idx_t;

  function automatic cam_word_t bitmap_update(input cam_word_t    word,
                                              input cam_bit_idx_t idx,
                                              input logic         set);
    cam_word_t mask;
    mask = cam_word_t'(1) << idx;
    return set ? (word | mask) : (word & ~mask);
  endfunction

endpackage

// File: rtl/cam_bram_ctrl.sv
// ---------------------------------------------------------------------------
// cam_bram_ctrl -- request front-end for one single-port BRAM slice of the
// RAM-based CAM. Each BRAM word is a bitmap with one bit per CAM entry; the
// BRAM address is a key chunk.
//
// Serialises onto the BRAM port:
//   SEARCH        read the bitmap at req_key, respond next cycle
//   INSERT/DELETE read, then write back with bit req_idx set/cleared
//   CLEAR         sweep every address to zero, respond on the last write
// After reset the same sweep (INIT) runs without a response.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_op/req_key/req_idx    opcode, key chunk (address), entry index
//   resp_valid                one-cycle response pulse, no backpressure
//   resp_match/hit/err        bitmap read, hit flag, index-range error
//   mem_en/wen/addr/din/dout  to the BRAM wrapper (1-cycle, read-first)
// ---------------------------------------------------------------------------
module cam_bram_ctrl
  import cam_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  cam_op_t                  req_op,
  input  logic [$clog2(DEPTH)-1:0] req_key,
  input  logic [$clog2(WIDTH)-1:0] req_idx,
  output logic                     resp_valid,
  output logic [WIDTH-1:0]         resp_match,
  output logic                     resp_hit,
  output logic                     resp_err,
  output logic                     mem_en,
  output logic                     mem_wen,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [WIDTH-1:0]         mem_din,
  input  logic [WIDTH-1:0]         mem_dout
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int IDX_W  = $clog2(WIDTH);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  // One extra bit so WIDTH itself is representable when it is a power of 2.
  localparam logic [IDX_W:0]    WIDTH_L   = (IDX_W + 1)'(WIDTH);

  ctrl_state_t       state;
  logic [ADDR_W-1:0] cnt;
  cam_op_t           op_q;
  logic [ADDR_W-1:0] key_q;
  logic [IDX_W-1:0]  idx_q;

  logic accept;
  logic idx_err;

  assign accept  = req_valid & req_ready;
  assign idx_err = {1'b0, idx_q} >= WIDTH_L;

  // NOTE: every register is written with <= so all flops sample the values
  // from before the edge; blocking assignments here would create ordering
  // races between blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        ST_INIT, ST_CLR: begin
          cnt <= cnt + ADDR_W'(1);
          // Compare against the last address, not a wrap, so that a
          // non-power-of-2 DEPTH stops at the right word.
          if (cnt == LAST_ADDR) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            cnt <= '0;
            case (req_op)
              OP_SEARCH: state <= ST_RESP;
              OP_CLEAR:  state <= ST_CLR;
              default:   state <= ST_MOD;
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the captured request fields carry no reset; they are only read in
  // states that are entered through an accept, which always loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= req_op;
      key_q <= req_key;
      idx_q <= req_idx;
    end
  end

  // Outputs are decoded from state; the accept-cycle read and the response
  // data (taken straight from mem_dout) cannot be registered without adding
  // a cycle of latency.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_match = '0;
    resp_hit   = 1'b0;
    resp_err   = 1'b0;
    mem_en     = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = cnt;
    mem_din    = '0;

    if (!rst) begin
      case (state)
        ST_INIT: begin
          mem_en  = 1'b1;
          mem_wen = 1'b1;
        end
        ST_CLR: begin
          mem_en     = 1'b1;
          mem_wen    = 1'b1;
          resp_valid = (cnt == LAST_ADDR);
        end
        ST_IDLE: begin
          req_ready = 1'b1;
          if (req_valid && req_op != OP_CLEAR) begin
            mem_en   = 1'b1;
            mem_addr = req_key;
          end
        end
        ST_RESP: begin
          resp_valid = 1'b1;
          resp_match = mem_dout;
          resp_hit   = |mem_dout;
        end
        ST_MOD: begin
          resp_valid = 1'b1;
          resp_match = mem_dout;
          resp_err   = idx_err;
          resp_hit   = ~idx_err & mem_dout[idx_q];
          // Duplicate INSERT / absent DELETE still rewrite the word; it is
          // simply unchanged.
          if (!idx_err) begin
            mem_en   = 1'b1;
            mem_wen  = 1'b1;
            mem_addr = key_q;
            mem_din  = WIDTH'(bitmap_update({{(CAM_WORD_MAX - WIDTH){1'b0}}, mem_dout},
                                            cam_bit_idx_t'(idx_q),
                                            op_q == OP_INSERT));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_bram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cam_bram_ctrl -- self-checking bench for cam_bram_ctrl with a
// behavioural read-first BRAM attached to its mem_* port. Expected responses
// come from a per-key bitmap array updated with plain bit arithmetic.
// ---------------------------------------------------------------------------
module tb_cam_bram_ctrl;
  import cam_pkg::*;

  localparam int DEPTH = 512;
  localparam int WIDTH = 36;
  localparam int AW    = 9;
  localparam int IW    = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  cam_op_t          req_op = OP_SEARCH;
  logic [AW-1:0]    req_key = '0;
  logic [IW-1:0]    req_idx = '0;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_match;
  logic             resp_hit;
  logic             resp_err;
  logic             mem_en;
  logic             mem_wen;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_din;
  logic [WIDTH-1:0] mem_dout = '0;

  always #5 clk = ~clk;

  cam_bram_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_key    (req_key),
    .req_idx    (req_idx),
    .resp_valid (resp_valid),
    .resp_match (resp_match),
    .resp_hit   (resp_hit),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  // Behavioural BRAM: 1-cycle read latency, read-first.
  logic [WIDTH-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= bram[mem_addr];
      if (mem_wen) bram[mem_addr] <= mem_din;
    end
  end

  // Reference contents of the CAM slice.
  logic [WIDTH-1:0] ref_mem [DEPTH];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // resp_* must read zero whenever resp_valid is low.
  int quiet_bad = 0;
  always @(negedge clk) begin
    #2;
    if (!resp_valid && (resp_match != '0 || resp_hit || resp_err)) quiet_bad++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic             valid;
    logic [WIDTH-1:0] match;
    logic             hit;
    logic             err;
    int               lat;
    logic             wen;
    logic [WIDTH-1:0] din;
    logic [AW-1:0]    waddr;
  } resp_t;

  typedef struct {
    cam_op_t          op;
    logic [AW-1:0]    key;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] match;
    logic             hit;
    logic             err;
  } vec_t;

  // Drive one request, wait for acceptance and the response (both bounded).
  task automatic issue(input cam_op_t op, input logic [AW-1:0] key,
                       input logic [IW-1:0] idx, output resp_t r);
    int waited;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    req_idx   = idx;
    #1;
    waited = 0;
    while (!req_ready && waited < 2000) begin
      @(negedge clk); #1; waited++;
    end
    check("req_ready_wait", req_ready, 1);
    if (op != OP_CLEAR) begin
      check("accept_mem_en", mem_en, 1);
      check("accept_mem_wen", mem_wen, 0);
      check("accept_mem_addr", mem_addr, key);
    end else begin
      check("accept_clear_no_mem", mem_en, 0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    r.lat = 1;
    while (!resp_valid && r.lat < 2000) begin
      @(negedge clk); #1; r.lat++;
    end
    r.valid = resp_valid;
    r.match = resp_match;
    r.hit   = resp_hit;
    r.err   = resp_err;
    r.wen   = mem_en & mem_wen;
    r.din   = mem_din;
    r.waddr = mem_addr;
    @(negedge clk); #1;
    check("resp_single_pulse", resp_valid, 0);
  endtask

  // Run one op, compare against the reference array, then update it.
  task automatic exec_op(input cam_op_t op, input logic [AW-1:0] key,
                         input logic [IW-1:0] idx, input string tag, output resp_t r);
    logic [WIDTH-1:0] e_match, e_din, one;
    logic             e_hit, e_err, e_wen;
    logic [AW-1:0]    e_waddr;
    int               e_lat;
    one = WIDTH'(1);
    e_match = '0; e_hit = 1'b0; e_err = 1'b0; e_wen = 1'b0;
    e_din = '0; e_waddr = key; e_lat = 1;
    case (op)
      OP_SEARCH: begin
        e_match = ref_mem[key];
        e_hit   = (ref_mem[key] != '0);
      end
      OP_INSERT, OP_DELETE: begin
        e_match = ref_mem[key];
        if (int'(idx) >= WIDTH) begin
          e_err = 1'b1;
        end else begin
          e_hit = ((ref_mem[key] >> idx) & one) != '0;
          e_din = (op == OP_INSERT) ? (ref_mem[key] | (one << idx))
                                    : (ref_mem[key] & ~(one << idx));
          e_wen = 1'b1;
          ref_mem[key] = e_din;
        end
      end
      default: begin
        e_lat   = DEPTH;
        e_wen   = 1'b1;
        e_waddr = AW'(DEPTH - 1);
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
      end
    endcase
    issue(op, key, idx, r);
    check({tag, "_valid"}, r.valid, 1);
    check({tag, "_latency"}, r.lat, e_lat);
    check({tag, "_match"}, r.match, e_match);
    check({tag, "_hit"}, r.hit, e_hit);
    check({tag, "_err"}, r.err, e_err);
    check({tag, "_wen"}, r.wen, e_wen);
    if (e_wen) begin
      check({tag, "_wr_data"}, r.din, e_din);
      check({tag, "_wr_addr"}, r.waddr, e_waddr);
    end
  endtask

  vec_t  vecs [16];
  resp_t r;

  initial begin
    int      sweep_bad;
    int      waited;
    int      sel;
    cam_op_t op;

    for (int k = 0; k < DEPTH; k++) begin
      bram[k]    = {$urandom(), $urandom()} >> (64 - WIDTH);
      ref_mem[k] = '0;
    end

    // ---------------- reset and INIT sweep ----------------
    rst = 1'b1;
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_wen", mem_wen, 0);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    sweep_bad = 0;
    for (int c = 0; c < DEPTH; c++) begin
      if (!(mem_en && mem_wen && mem_addr == AW'(c) && mem_din == '0 &&
            !req_ready && !resp_valid)) sweep_bad++;
      @(negedge clk); #1;
    end
    check("init_sweep_cycles", sweep_bad, 0);
    check("init_done_ready", req_ready, 1);
    check("init_done_no_resp", resp_valid, 0);

    // ---------------- directed vector table ----------------
    vecs[0]  = '{OP_INSERT, 9'h0A5, 6'd3,  36'h0,           1'b0, 1'b0};
    vecs[1]  = '{OP_SEARCH, 9'h0A5, 6'd0,  36'h8,           1'b1, 1'b0};
    vecs[2]  = '{OP_INSERT, 9'h0A5, 6'd35, 36'h8,           1'b0, 1'b0};
    vecs[3]  = '{OP_INSERT, 9'h0A5, 6'd35, 36'h8_0000_0008, 1'b1, 1'b0};
    vecs[4]  = '{OP_DELETE, 9'h0A5, 6'd3,  36'h8_0000_0008, 1'b1, 1'b0};
    vecs[5]  = '{OP_SEARCH, 9'h0A5, 6'd0,  36'h8_0000_0000, 1'b1, 1'b0};
    vecs[6]  = '{OP_INSERT, 9'h0A5, 6'd36, 36'h8_0000_0000, 1'b0, 1'b1};
    vecs[7]  = '{OP_SEARCH, 9'h0A5, 6'd0,  36'h8_0000_0000, 1'b1, 1'b0};
    vecs[8]  = '{OP_DELETE, 9'h033, 6'd5,  36'h0,           1'b0, 1'b0};
    vecs[9]  = '{OP_SEARCH, 9'h033, 6'd0,  36'h0,           1'b0, 1'b0};
    vecs[10] = '{OP_INSERT, 9'h000, 6'd0,  36'h0,           1'b0, 1'b0};
    vecs[11] = '{OP_INSERT, 9'h1FF, 6'd35, 36'h0,           1'b0, 1'b0};
    vecs[12] = '{OP_CLEAR,  9'h000, 6'd0,  36'h0,           1'b0, 1'b0};
    vecs[13] = '{OP_SEARCH, 9'h000, 6'd0,  36'h0,           1'b0, 1'b0};
    vecs[14] = '{OP_SEARCH, 9'h1FF, 6'd0,  36'h0,           1'b0, 1'b0};
    vecs[15] = '{OP_SEARCH, 9'h0A5, 6'd0,  36'h0,           1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      exec_op(vecs[i].op, vecs[i].key, vecs[i].idx, $sformatf("vec%0d", i), r);
      check($sformatf("vec%0d_tbl_match", i), r.match, vecs[i].match);
      check($sformatf("vec%0d_tbl_hit", i), r.hit, vecs[i].hit);
      check($sformatf("vec%0d_tbl_err", i), r.err, vecs[i].err);
    end

    // ---------------- reset during MOD ----------------
    exec_op(OP_INSERT, 9'h007, 6'd2, "pre_rst_ins", r);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_INSERT;
    req_key   = 9'h007;
    req_idx   = 6'd1;
    #1;
    check("rstmod_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rstmod_no_resp", resp_valid, 0);
    check("rstmod_no_write", mem_wen, 0);
    check("rstmod_no_en", mem_en, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmod_restart_addr", mem_addr, 0);
    check("rstmod_restart_wen", mem_wen, 1);
    check("rstmod_restart_busy", req_ready, 0);
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
    waited = 0;
    while (!req_ready && waited < 2000) begin
      @(negedge clk); #1; waited++;
    end
    check("rstmod_init_len", waited, DEPTH);
    exec_op(OP_SEARCH, 9'h007, 6'd0, "rstmod_search", r);
    check("rstmod_search_zero", r.match, 0);

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 200; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 2)       op = OP_CLEAR;
      else if (sel < 35) op = OP_SEARCH;
      else if (sel < 70) op = OP_INSERT;
      else               op = OP_DELETE;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      exec_op(op,
              ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                          : AW'($urandom_range(0, 7)),
              IW'($urandom_range(0, 39)),
              $sformatf("rnd%0d", n), r);
    end

    check("resp_quiet_when_invalid", quiet_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
